lvds_echo_buffer: RTL



---
 rtl/lvds_echo_buffer.sv | 99 +++++++++
 1 files changed

// File: rtl/lvds_echo_buffer.sv
// Echo stage: pulls words from the LVDS receive dequeue port, buffers them in a small FIFO,
// optionally scrambles them, and returns them to the transmit side while checking sequence order.
module lvds_echo_buffer #(
    parameter int          DEPTH     = 8,
    parameter int          AW        = 3,
    parameter logic [31:0] XOR_MASK  = 32'h0000_0000,
    parameter bit          CHECK_SEQ = 1'b1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] rx_data,
    input  logic        rx_rdy,
    output logic        rx_en,
    output logic [31:0] tx_data,
    input  logic        tx_rdy,
    output logic        tx_en,
    output logic [15:0] echo_count,
    output logic        seq_err,
    output logic [7:0]  led
);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          full, empty;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign rx_en   = rx_rdy & ~full & ~RST;
    assign tx_en   = tx_rdy & ~empty & ~RST;
    assign tx_data = mem[rd_ptr] ^ XOR_MASK;
    assign led     = {seq_err, full, empty, echo_count[4:0]};

    // Storage is deliberately left unreset; only the pointers define what is valid.
    always_ff @(posedge CLK) begin
        if (rx_en)
            mem[wr_ptr] <= rx_data;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            echo_count <= '0;
        end else begin
            if (rx_en)
                wr_ptr <= wr_ptr + AW'(1);
            if (tx_en) begin
                rd_ptr     <= rd_ptr + AW'(1);
                echo_count <= echo_count + 16'd1;
            end
            case ({rx_en, tx_en})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    generate
        if (CHECK_SEQ) begin : g_seq
            typedef enum logic {S_IDLE, S_TRACK} seq_state_t;
            seq_state_t  state, state_nxt;
            logic [31:0] expected, expected_nxt;
            logic        err_r, err_nxt;

            always_ff @(posedge CLK) begin
                if (RST) begin
                    state    <= S_IDLE;
                    expected <= '0;
                    err_r    <= 1'b0;
                end else begin
                    state    <= state_nxt;
                    expected <= expected_nxt;
                    err_r    <= err_nxt;
                end
            end

            // Every accepted word becomes the new baseline, so one bad word flags once.
            always_comb begin
                state_nxt    = state;
                expected_nxt = expected;
                err_nxt      = err_r;
                if (rx_en) begin
                    state_nxt    = S_TRACK;
                    expected_nxt = rx_data + 32'd1;
                    if (state == S_TRACK && rx_data != expected)
                        err_nxt = 1'b1;
                end
            end

            assign seq_err = err_r;
        end else begin : g_noseq
            assign seq_err = 1'b0;
        end
    endgenerate
endmodule
